alu_issue_ctrl: RTL and testbench

//  Instruction issuer driving the 3-stage pipelined ALU's rs1/rs2/rd/opcode inputs from a small program RAM.
//  The ALU has no forwarding and writes regbank[rd] on every clock, so this block inserts bubbles on RAW hazards
//  and drives a harmless NOP whenever it has no real instruction to issue.
//  It also reports which ALU Out values are real results (res_valid/res_rd, aligned to ALU Out).

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu_hazard_chk.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the pipelined ALU and its instruction issuer:
//   opcode values, instruction field layout, the default bubble register,
//   and the decoded-instruction / scoreboard-entry / FSM-state types.
//   No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int REG_W   = 3;

    // Instruction word layout: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2.
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_NOTA  = 4'd6;
    localparam logic [OP_W-1:0] OP_NOTB  = 4'd7;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd8;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd9;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd10;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd11;
    localparam logic [OP_W-1:0] OP_HALT  = 4'd15;

    // Scratch register written by bubbles; programs never reference it.
    localparam logic [REG_W-1:0] NOP_REG_DEF = 3'd7;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } instr_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t i;
        i.op  = w[OP_LSB  +: OP_W];
        i.rd  = w[RD_LSB  +: REG_W];
        i.rs1 = w[RS1_LSB +: REG_W];
        i.rs2 = w[RS2_LSB +: REG_W];
        return i;
    endfunction

endpackage

// File: rtl/alu_hazard_chk.sv
// -----------------------------------------------------------------------------
// alu_hazard_chk
//   Combinational RAW check for the instruction at the fetch point against the
//   two in-flight words held in the scoreboard.
//   Ports:
//     instr    in   decoded candidate instruction
//     sb0      in   {valid, rd} of the word currently on the ALU inputs
//     sb1      in   {valid, rd} of the word issued one cycle earlier
//     stall    out  a used source matches a valid in-flight destination
//     uses_rs1 out  opcode reads rs1
//     uses_rs2 out  opcode reads rs2
// -----------------------------------------------------------------------------
module alu_hazard_chk
    import alu_pkg::*;
(
    input  instr_t    instr,
    input  sb_entry_t sb0,
    input  sb_entry_t sb1,
    output logic      stall,
    output logic      uses_rs1,
    output logic      uses_rs2
);

    function automatic logic in_flight(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.valid && (e.rd == r);
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it
        // unassigned; that keeps this block purely combinational (no latches).
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (instr.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_NOTA, OP_PASSA, OP_SHR, OP_SHL: uses_rs1 = 1'b1;
            OP_NOTB, OP_PASSB:                 uses_rs2 = 1'b1;
            // Clears (12-14) and HALT read no source.
            default: ;
        endcase

        stall = (uses_rs1 && (in_flight(sb0, instr.rs1) || in_flight(sb1, instr.rs1)))
             || (uses_rs2 && (in_flight(sb0, instr.rs2) || in_flight(sb1, instr.rs2)));
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issues instructions from a small program RAM to a 3-stage ALU that has no
//   forwarding, inserting bubbles on RAW hazards and driving a NOP (pass A into
//   the scratch register) whenever no real instruction is issued. Also tracks
//   which ALU Out values are real results.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     prog_we/addr/wdata         program RAM write port (ignored while busy)
//     start                      run pulse, sampled only in IDLE
//     opcode, rs1, rs2, rd       registered ALU controls
//     busy                       high in RUN and DRAIN
//     done                       1-cycle pulse after the final regbank write
//     res_valid, res_rd          ALU Out holds a real result for res_rd
//     issue_cnt, stall_cnt       per-run real issues / hazard bubbles (wrap)
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned      PC_W    = 4,
    parameter logic [REG_W-1:0] NOP_REG = NOP_REG_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               start,
    output logic [OP_W-1:0]    opcode,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [REG_W-1:0]   rd,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    output logic [REG_W-1:0]   res_rd,
    output logic [7:0]         issue_cnt,
    output logic [7:0]         stall_cnt
);

    localparam int DEPTH = 1 << PC_W;
    localparam instr_t NOP_INSTR = '{op: OP_PASSA, rd: NOP_REG, rs1: NOP_REG, rs2: '0};

    logic [INSTR_W-1:0] prog_mem [0:DEPTH-1];

    state_t          state_q,     state_d;
    logic [PC_W-1:0] pc_q,        pc_d;
    instr_t          out_q,       out_d;
    sb_entry_t       sb0_q,       sb0_d;
    sb_entry_t       sb1_q,       sb1_d;
    sb_entry_t       res0_q,      res0_d;
    sb_entry_t       res1_q,      res1_d;
    logic            drain_q,     drain_d;
    logic            done_q,      done_d;
    logic            busy_q,      busy_d;
    logic [7:0]      issue_cnt_q, issue_cnt_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;

    instr_t fetch;
    logic   hz_stall, hz_uses_rs1, hz_uses_rs2, run_stall;

    // NOTE: the program RAM is deliberately left out of reset; reset only
    // restarts the issuer, and a loaded program survives it.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) prog_mem[prog_addr] <= prog_wdata;
    end

    assign fetch = decode(prog_mem[pc_q]);

    alu_hazard_chk u_hazard_chk (
        .instr    (fetch),
        .sb0      (sb0_q),
        .sb1      (sb1_q),
        .stall    (hz_stall),
        .uses_rs1 (hz_uses_rs1),
        .uses_rs2 (hz_uses_rs2)
    );

    // Only an instruction that reads a source can ever wait on one.
    assign run_stall = hz_stall && (hz_uses_rs1 || hz_uses_rs2);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_d       = NOP_INSTR;
        sb0_d       = '0;          // bubbles carry no destination
        sb1_d       = sb0_q;
        res0_d      = sb0_q;       // ALU samples the word one edge later ...
        res1_d      = res0_q;      // ... and presents its result one edge after that
        drain_d     = drain_q;
        done_d      = 1'b0;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    pc_d        = '0;
                    issue_cnt_d = '0;
                    stall_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (run_stall) begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end else if (fetch.op == OP_HALT) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    out_d       = fetch;
                    sb0_d       = '{valid: 1'b1, rd: fetch.rd};
                    pc_d        = pc_q + PC_W'(1);
                    issue_cnt_d = issue_cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                // Two bubble cycles let the last real instruction reach the regbank.
                if (drain_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            out_q       <= NOP_INSTR;
            sb0_q       <= '0;
            sb1_q       <= '0;
            res0_q      <= '0;
            res1_q      <= '0;
            drain_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            sb0_q       <= sb0_d;
            sb1_q       <= sb1_d;
            res0_q      <= res0_d;
            res1_q      <= res1_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign opcode    = out_q.op;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res1_q.valid;
    assign res_rd    = res1_q.rd;
    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl. Expected issue schedules come from
//   a register-ready-time model: a result written by an instruction issued at
//   edge t can be read by an instruction issued no earlier than edge t+3.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int PC_W  = 4;
    localparam int DEPTH = 1 << PC_W;
    localparam int MAXN  = 96;
    localparam logic [12:0] NOP_OUT = {4'd8, 3'd7, 3'd7, 3'd0};

    logic        clk = 1'b0;
    logic        reset, prog_we, start;
    logic [PC_W-1:0] prog_addr;
    logic [15:0] prog_wdata;
    logic [3:0]  opcode;
    logic [2:0]  rs1, rs2, rd, res_rd;
    logic        busy, done, res_valid;
    logic [7:0]  issue_cnt, stall_cnt;

    alu_issue_ctrl #(.PC_W(PC_W), .NOP_REG(3'd7)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .opcode     (opcode),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .busy       (busy),
        .done       (done),
        .res_valid  (res_valid),
        .res_rd     (res_rd),
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rdv, input int a, input int b);
        return {op[3:0], rdv[2:0], a[2:0], b[2:0], 3'b000};
    endfunction

    // Operand-use table.
    function automatic bit uses_a(input int op);
        return (op <= 6) || (op == 8) || (op == 10) || (op == 11);
    endfunction
    function automatic bit uses_b(input int op);
        return (op <= 5) || (op == 7) || (op == 9);
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] prog_img [DEPTH];
    bit          exp_real [MAXN];
    logic [15:0] exp_word [MAXN];
    int          halt_t;
    int          m_issue;

    task automatic build_model(input int limit);
        int ready [8];
        int t, pc, nt, op, rdv, ra, rb;
        logic [15:0] w;
        bit stop;
        for (int i = 0; i < MAXN; i++) begin
            exp_real[i] = 1'b0;
            exp_word[i] = '0;
        end
        for (int r = 0; r < 8; r++) ready[r] = -100;
        t = 0; pc = 0; m_issue = 0; halt_t = -1; stop = 1'b0;
        while (!stop && t < limit) begin
            w   = prog_img[pc];
            op  = 32'(w[15:12]);
            rdv = 32'(w[11:9]);
            ra  = 32'(w[8:6]);
            rb  = 32'(w[5:3]);
            if (op == 15) begin
                halt_t = t + 1;
                stop   = 1'b1;
            end else begin
                nt = t + 1;
                if (uses_a(op) && ready[ra] > nt) nt = ready[ra];
                if (uses_b(op) && ready[rb] > nt) nt = ready[rb];
                t = nt;
                if (t < MAXN) begin
                    exp_real[t] = 1'b1;
                    exp_word[t] = w;
                end
                ready[rdv] = t + 3;
                m_issue++;
                pc = (pc + 1) % DEPTH;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_prog();
        for (int a = 0; a < DEPTH; a++) begin
            prog_we    = 1'b1;
            prog_addr  = a[PC_W-1:0];
            prog_wdata = prog_img[a];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    task automatic check_nop_outputs(input string tag);
        check({tag, " out"}, 32'({opcode, rd, rs1, rs2}), 32'(NOP_OUT));
    endtask

    // Starts a run (optionally writing word 0 in the same cycle), then checks
    // every cycle against the model up to one cycle past done or n_max edges.
    // inject_n > 0 pulses start and a write to address 0 while running.
    task automatic run_prog(input string tag, input int n_max, input bit we0,
                            input logic [15:0] w0, input int inject_n, output int done_at);
        int last;
        logic [12:0] exp_o;
        logic [15:0] w;
        bit exp_busy, exp_done, exp_rv;
        done_at = -1;
        start = 1'b1;
        if (we0) begin
            prog_we    = 1'b1;
            prog_addr  = '0;
            prog_wdata = w0;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        check({tag, " busy@start"}, 32'(busy), 32'(1));
        check_nop_outputs({tag, " @start"});

        last = (halt_t >= 0) ? halt_t + 3 : n_max;
        if (last > n_max) last = n_max;
        for (int n = 1; n <= last; n++) begin
            if (n == inject_n) begin
                start      = 1'b1;
                prog_we    = 1'b1;
                prog_addr  = '0;
                prog_wdata = enc(15, 0, 0, 0);
            end
            @(posedge clk); #1;
            start   = 1'b0;
            prog_we = 1'b0;
            w        = exp_word[n];
            exp_o    = exp_real[n] ? w[15:3] : NOP_OUT;
            exp_busy = (halt_t < 0) || (n < halt_t + 2);
            exp_done = (halt_t >= 0) && (n == halt_t + 2);
            exp_rv   = (n >= 2) && exp_real[n-2];
            check($sformatf("%s out n=%0d", tag, n), 32'({opcode, rd, rs1, rs2}), 32'(exp_o));
            check($sformatf("%s busy n=%0d", tag, n), 32'(busy), 32'(exp_busy));
            check($sformatf("%s done n=%0d", tag, n), 32'(done), 32'(exp_done));
            check($sformatf("%s res_valid n=%0d", tag, n), 32'(res_valid), 32'(exp_rv));
            if (exp_rv) begin
                w = exp_word[n-2];
                check($sformatf("%s res_rd n=%0d", tag, n), 32'(res_rd), 32'(w[11:9]));
            end
            if (done && done_at < 0) done_at = n;
        end
        if (halt_t >= 0 && last == halt_t + 3) begin
            check({tag, " issue_cnt"}, 32'(issue_cnt), 32'(m_issue[7:0]));
            check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(halt_t - 1 - m_issue));
        end
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'(0));
        check_nop_outputs(tag);
        check({tag, " done"}, 32'(done), 32'(0));
        check({tag, " res_valid"}, 32'(res_valid), 32'(0));
        check({tag, " res_rd"}, 32'(res_rd), 32'(0));
        check({tag, " issue_cnt"}, 32'(issue_cnt), 32'(0));
        check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(0));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string           name;
        logic [3:0][15:0] code;
        int              exp_issue;
        int              exp_stall;
        int              exp_done;   // edge after start at which done is seen
    } vec_t;

    vec_t tbl [6];

    initial begin
        int done_at;
        int len, op;

        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;

        // Independent pair: issued back-to-back.
        tbl[0].name = "indep";
        tbl[0].code[0] = enc(6, 1, 0, 0); tbl[0].code[1] = enc(6, 2, 0, 0);
        tbl[0].code[2] = enc(15, 0, 0, 0); tbl[0].code[3] = enc(15, 0, 0, 0);
        tbl[0].exp_issue = 2; tbl[0].exp_stall = 0; tbl[0].exp_done = 5;
        // Distance-1 RAW: r2 = r1 + r1 waits 2 bubbles.
        tbl[1].name = "raw_d1";
        tbl[1].code[0] = enc(6, 1, 0, 0); tbl[1].code[1] = enc(0, 2, 1, 1);
        tbl[1].code[2] = enc(15, 0, 0, 0); tbl[1].code[3] = enc(15, 0, 0, 0);
        tbl[1].exp_issue = 2; tbl[1].exp_stall = 2; tbl[1].exp_done = 7;
        // Distance-2 RAW: r2 = r1 + r1 two behind the r1 write, 1 bubble.
        tbl[2].name = "raw_d2";
        tbl[2].code[0] = enc(6, 1, 0, 0); tbl[2].code[1] = enc(6, 3, 0, 0);
        tbl[2].code[2] = enc(0, 2, 1, 1); tbl[2].code[3] = enc(15, 0, 0, 0);
        tbl[2].exp_issue = 3; tbl[2].exp_stall = 1; tbl[2].exp_done = 7;
        // Unary op 6 ignores its rs2 field.
        tbl[3].name = "unary_skip";
        tbl[3].code[0] = enc(6, 1, 0, 0); tbl[3].code[1] = enc(6, 2, 0, 1);
        tbl[3].code[2] = enc(15, 0, 0, 0); tbl[3].code[3] = enc(15, 0, 0, 0);
        tbl[3].exp_issue = 2; tbl[3].exp_stall = 0; tbl[3].exp_done = 5;
        // Op 9 reads rs2 only: dependency on the previous write costs 2 bubbles.
        tbl[4].name = "rs2_only";
        tbl[4].code[0] = enc(6, 1, 0, 0); tbl[4].code[1] = enc(9, 2, 0, 1);
        tbl[4].code[2] = enc(15, 0, 0, 0); tbl[4].code[3] = enc(15, 0, 0, 0);
        tbl[4].exp_issue = 2; tbl[4].exp_stall = 2; tbl[4].exp_done = 7;
        // Clear reads nothing, but its rd is still a hazard for the next reader.
        tbl[5].name = "clear_dep";
        tbl[5].code[0] = enc(6, 1, 0, 0); tbl[5].code[1] = enc(12, 2, 1, 1);
        tbl[5].code[2] = enc(8, 3, 2, 0); tbl[5].code[3] = enc(15, 0, 0, 0);
        tbl[5].exp_issue = 3; tbl[5].exp_stall = 2; tbl[5].exp_done = 8;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'(0));
        check_nop_outputs("reset");
        check("reset done", 32'(done), 32'(0));
        check("reset res_valid", 32'(res_valid), 32'(0));
        check("reset res_rd", 32'(res_rd), 32'(0));
        check("reset issue_cnt", 32'(issue_cnt), 32'(0));
        check("reset stall_cnt", 32'(stall_cnt), 32'(0));
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int a = 0; a < DEPTH; a++) prog_img[a] = (a < 4) ? tbl[v].code[a] : enc(15, 0, 0, 0);
            load_prog();
            build_model(MAXN);
            run_prog(tbl[v].name, MAXN, 1'b0, '0, 0, done_at);
            check({tbl[v].name, " done_edge"}, 32'(done_at), 32'(tbl[v].exp_done));
            check({tbl[v].name, " tbl_issue"}, 32'(issue_cnt), 32'(tbl[v].exp_issue));
            check({tbl[v].name, " tbl_stall"}, 32'(stall_cnt), 32'(tbl[v].exp_stall));
        end

        // start and prog_we while running are ignored; a re-run sees the same RAM.
        for (int a = 0; a < DEPTH; a++) prog_img[a] = (a < 4) ? tbl[0].code[a] : enc(15, 0, 0, 0);
        load_prog();
        build_model(MAXN);
        run_prog("busy_ignore", MAXN, 1'b0, '0, 2, done_at);
        run_prog("busy_rerun", MAXN, 1'b0, '0, 0, done_at);

        // Same-cycle write and start in IDLE: the new word 0 is the first issued.
        prog_img[0] = enc(6, 4, 0, 0);
        build_model(MAXN);
        run_prog("we_start", MAXN, 1'b1, prog_img[0], 0, done_at);

        // Program without HALT: pc wraps and word 0 is issued again; only reset stops it.
        for (int a = 0; a < DEPTH; a++) prog_img[a] = enc(6, (a % 6) + 1, 0, 0);
        load_prog();
        build_model(40);
        run_prog("wrap", 40, 1'b0, '0, 0, done_at);
        check("wrap still busy", 32'(busy), 32'(1));
        reset_check("wrap reset");

        // Reset two cycles into a run aborts it; the next start runs from pc 0.
        for (int a = 0; a < DEPTH; a++) prog_img[a] = (a < 4) ? tbl[1].code[a] : enc(15, 0, 0, 0);
        load_prog();
        build_model(MAXN);
        run_prog("abort", 2, 1'b0, '0, 0, done_at);
        reset_check("midrun reset");
        build_model(MAXN);
        run_prog("after_abort", MAXN, 1'b0, '0, 0, done_at);

        // Random programs over a small register set to provoke hazards.
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 15);
            for (int a = 0; a < DEPTH; a++) begin
                if (a < len) begin
                    op = $urandom_range(0, 14);
                    prog_img[a] = enc(op, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
                end else begin
                    prog_img[a] = enc(15, 0, 0, 0);
                end
            end
            load_prog();
            build_model(MAXN);
            run_prog($sformatf("rand%0d", it), MAXN, 1'b0, '0, 0, done_at);
            check($sformatf("rand%0d done_edge", it), 32'(done_at), 32'(halt_t + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
